// File: rtl/npu_pkg.sv
// Shared types and sizing for the NPU conv1 control path.
package npu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT,
    ST_HAND,
    ST_DONE,
    ST_ERR
  } conv1_state_e;

  localparam int CONV1_CHAN    = 10;
  localparam int CONV1_CHAN_W  = 4;
  localparam int CONV1_TIMEOUT = 200000;

endpackage

// File: rtl/conv1_seq_watchdog.sv
// Clear/enable cycle counter whose terminal count marks a stalled conv1 datapath.
module seq_watchdog #(
  parameter int TIMEOUT = 200000,
  parameter int TMO_W   = 18
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TMO_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en)
      count <= count + TMO_W'(1);
  end

  assign expired = (count == TMO_W'(TIMEOUT - 1));

endmodule

// File: rtl/conv1_seq.sv
// Channel sequencer: triggers a conv1 pass, checks channel order and hands each
// finished channel buffer to the downstream consumer over valid/ready.
module conv1_seq
  import npu_pkg::*;
#(
  parameter int CHAN    = CONV1_CHAN,
  parameter int CHAN_W  = CONV1_CHAN_W,
  parameter int TIMEOUT = CONV1_TIMEOUT,
  parameter int TMO_W   = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic              err_order,
  output logic              err_overrun,
  output logic              conv_trigger,
  input  logic              conv_valid,
  input  logic [CHAN_W-1:0] conv_chan,
  output logic              cons_valid,
  output logic [CHAN_W-1:0] cons_chan,
  output logic              cons_last,
  input  logic              cons_ready
);

  localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(CHAN - 1);

  conv1_state_e      state, state_nxt;
  logic [CHAN_W-1:0] exp_chan, exp_nxt;
  logic              pend, pend_nxt;
  logic              prev_valid;
  logic              rise;
  logic              cv_nxt, cl_nxt;
  logic [CHAN_W-1:0] cc_nxt;
  logic              eto_nxt, eord_nxt, eovr_nxt;
  logic              wd_clr, wd_en, wd_expired;

  assign rise   = conv_valid & ~prev_valid;
  assign wd_clr = (state == ST_TRIG) | ((state == ST_WAIT) & (rise | pend));
  assign wd_en  = (state == ST_WAIT);

  seq_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TMO_W   (TMO_W)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    exp_nxt   = exp_chan;
    pend_nxt  = pend;
    cv_nxt    = cons_valid;
    cc_nxt    = cons_chan;
    cl_nxt    = cons_last;
    eto_nxt   = err_timeout;
    eord_nxt  = err_order;
    eovr_nxt  = err_overrun;
    case (state)
      ST_IDLE, ST_ERR: begin
        if (start) begin
          state_nxt = ST_TRIG;
          eto_nxt   = 1'b0;
          eord_nxt  = 1'b0;
          eovr_nxt  = 1'b0;
        end
      end
      ST_TRIG: begin
        exp_nxt   = '0;
        pend_nxt  = 1'b0;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // A pending edge (seen during the previous accept) is judged against the live channel index.
        if (rise | pend) begin
          pend_nxt = 1'b0;
          if (conv_chan == exp_chan) begin
            cv_nxt    = 1'b1;
            cc_nxt    = conv_chan;
            cl_nxt    = (exp_chan == LAST_CHAN);
            state_nxt = ST_HAND;
          end else begin
            eord_nxt  = 1'b1;
            state_nxt = ST_ERR;
          end
        end else if (wd_expired) begin
          eto_nxt   = 1'b1;
          state_nxt = ST_ERR;
        end
      end
      ST_HAND: begin
        if (cons_ready) begin
          cv_nxt = 1'b0;
          if (cons_last) begin
            state_nxt = ST_DONE;
          end else begin
            exp_nxt   = exp_chan + CHAN_W'(1);
            pend_nxt  = rise;
            state_nxt = ST_WAIT;
          end
        end else if (rise) begin
          eovr_nxt  = 1'b1;
          cv_nxt    = 1'b0;
          state_nxt = ST_ERR;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (abort) begin
      state_nxt = ST_IDLE;
      cv_nxt    = 1'b0;
    end
  end

  // Registered outputs are derived from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_chan     <= '0;
      pend         <= 1'b0;
      prev_valid   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      conv_trigger <= 1'b0;
      cons_valid   <= 1'b0;
      cons_chan    <= '0;
      cons_last    <= 1'b0;
      err_timeout  <= 1'b0;
      err_order    <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      exp_chan     <= exp_nxt;
      pend         <= pend_nxt;
      prev_valid   <= conv_valid;
      busy         <= (state_nxt == ST_TRIG) | (state_nxt == ST_WAIT) | (state_nxt == ST_HAND);
      done         <= (state_nxt == ST_DONE);
      conv_trigger <= (state_nxt == ST_TRIG);
      cons_valid   <= cv_nxt;
      cons_chan    <= cc_nxt;
      cons_last    <= cl_nxt;
      err_timeout  <= eto_nxt;
      err_order    <= eord_nxt;
      err_overrun  <= eovr_nxt;
    end
  end

endmodule

// File: tb/tb_conv1_seq.sv
// Directed bench for conv1_seq: a transaction-level model predicts every output each
// cycle, and literal expectations pin counts, latencies and error flags per scenario.
module tb_conv1_seq;

  localparam int CHAN = 10;
  localparam int CW   = 4;
  localparam int TMO  = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          busy, done, err_timeout, err_order, err_overrun, conv_trigger;
  logic          conv_valid = 1'b0;
  logic [CW-1:0] conv_chan = '0;
  logic          cons_valid;
  logic [CW-1:0] cons_chan;
  logic          cons_last;
  logic          cons_ready = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  conv1_seq #(.CHAN(CHAN), .CHAN_W(CW), .TIMEOUT(TMO), .TMO_W(7)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .err_timeout(err_timeout), .err_order(err_order),
    .err_overrun(err_overrun), .conv_trigger(conv_trigger),
    .conv_valid(conv_valid), .conv_chan(conv_chan),
    .cons_valid(cons_valid), .cons_chan(cons_chan), .cons_last(cons_last),
    .cons_ready(cons_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a pass is either triggering, waiting for a channel,
  // offering a channel, or finishing; flags are sticky until the next start.
  bit m_busy = 0, m_trig = 0, m_done = 0, m_cv = 0, m_cl = 0, m_pend = 0, m_prev = 0;
  bit m_eto = 0, m_eord = 0, m_eovr = 0;
  int m_cc = 0, m_need = 0, m_ticks = 0;
  wire m_rise = conv_valid && !m_prev;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0; m_trig <= 0; m_done <= 0; m_cv <= 0; m_cl <= 0; m_pend <= 0;
      m_prev <= 0; m_eto <= 0; m_eord <= 0; m_eovr <= 0; m_cc <= 0; m_need <= 0; m_ticks <= 0;
    end else begin
      m_prev <= conv_valid;
      if (abort) begin
        m_busy <= 0; m_trig <= 0; m_done <= 0; m_cv <= 0;
      end else if (m_trig) begin
        m_trig <= 0; m_need <= 0; m_ticks <= 0; m_pend <= 0;
      end else if (m_done) begin
        m_done <= 0;
      end else if (!m_busy) begin
        if (start) begin
          m_trig <= 1; m_busy <= 1; m_eto <= 0; m_eord <= 0; m_eovr <= 0;
        end
      end else if (!m_cv) begin
        if (m_rise || m_pend) begin
          m_pend <= 0;
          if (int'(conv_chan) == m_need) begin
            m_cv <= 1; m_cc <= int'(conv_chan); m_cl <= (m_need == CHAN - 1); m_ticks <= 0;
          end else begin
            m_eord <= 1; m_busy <= 0;
          end
        end else if (m_ticks == TMO - 1) begin
          m_eto <= 1; m_busy <= 0;
        end else begin
          m_ticks <= m_ticks + 1;
        end
      end else begin
        if (cons_ready) begin
          m_cv <= 0;
          if (m_cl) begin
            m_busy <= 0; m_done <= 1;
          end else begin
            m_need <= m_need + 1; m_pend <= m_rise;
          end
        end else if (m_rise) begin
          m_eovr <= 1; m_cv <= 0; m_busy <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", int'(busy), int'(m_busy));
    chk("conv_trigger", int'(conv_trigger), int'(m_trig));
    chk("done", int'(done), int'(m_done));
    chk("cons_valid", int'(cons_valid), int'(m_cv));
    chk("err_timeout", int'(err_timeout), int'(m_eto));
    chk("err_order", int'(err_order), int'(m_eord));
    chk("err_overrun", int'(err_overrun), int'(m_eovr));
    if (m_cv) begin
      chk("cons_chan", int'(cons_chan), m_cc);
      chk("cons_last", int'(cons_last), int'(m_cl));
    end
  end

  // Consumer: 0 = always ready, 1 = stall stall_len cycles per buffer, 2 = manual.
  int rmode = 0, stall_len = 0, stall_cnt = 0;
  bit man_rdy = 0;
  always begin
    @(negedge clk);
    #1;
    if (rmode == 0) cons_ready = 1'b1;
    else if (rmode == 2) cons_ready = man_rdy;
    else if (!cons_valid) begin stall_cnt = 0; cons_ready = 1'b0; end
    else if (stall_cnt < stall_len) begin stall_cnt++; cons_ready = 1'b0; end
    else cons_ready = 1'b1;
  end

  // Event monitor for the literal expectations.
  int cyc = 0, n_trig = 0, n_beat = 0, n_last = 0, n_done = 0, last_acc_cyc = -1, done_cyc = -1;
  int beat_q[$];
  always begin
    @(negedge clk);
    #2;
    cyc++;
    if (conv_trigger) n_trig++;
    if (cons_valid && cons_ready) begin
      beat_q.push_back(int'(cons_chan));
      n_beat++;
      if (cons_last) begin n_last++; last_acc_cyc = cyc; end
    end
    if (done) begin n_done++; done_cyc = cyc; end
  end

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic emit(input int ch, input int spacing);
    @(negedge clk); conv_chan = CW'(ch); conv_valid = 1'b1;
    repeat (3) @(negedge clk);
    conv_valid = 1'b0;
    repeat (spacing - 4) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL global_time_limit: got timeout, expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int k, b_trig, b_beat, b_last, b_done, b_q;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cons_valid", int'(cons_valid), 0);
    chk("rst_flags", int'({err_timeout, err_order, err_overrun, done, conv_trigger}), 0);
    rst = 1'b0;

    // 1: nominal pass, consumer always ready
    rmode = 0;
    b_trig = n_trig; b_beat = n_beat; b_last = n_last; b_done = n_done; b_q = beat_q.size();
    do_start();
    for (int c = 0; c < CHAN; c++) emit(c, 20);
    repeat (5) @(negedge clk);
    #3;
    chk("t1_triggers", n_trig - b_trig, 1);
    chk("t1_beats", n_beat - b_beat, 10);
    chk("t1_last_beats", n_last - b_last, 1);
    chk("t1_dones", n_done - b_done, 1);
    chk("t1_done_latency", done_cyc - last_acc_cyc, 1);
    for (int i = 0; i < CHAN; i++) chk("t1_beat_chan", beat_q[b_q + i], i);
    chk("t1_flags", int'({err_timeout, err_order, err_overrun}), 0);

    // 2: backpressure, 15 stall cycles per buffer
    rmode = 1; stall_len = 15;
    b_beat = n_beat; b_done = n_done;
    do_start();
    for (int c = 0; c < CHAN; c++) emit(c, 20);
    repeat (5) @(negedge clk);
    #3;
    chk("t2_beats", n_beat - b_beat, 10);
    chk("t2_dones", n_done - b_done, 1);
    chk("t2_overrun", int'(err_overrun), 0);

    // 3: overrun with a 30-cycle stall, then restart clears the flag
    rmode = 1; stall_len = 30;
    do_start();
    emit(0, 20);
    emit(1, 20);
    chk("t3_overrun", int'(err_overrun), 1);
    chk("t3_busy", int'(busy), 0);
    chk("t3_cons_valid", int'(cons_valid), 0);
    rmode = 0;
    do_start();
    chk("t3_retrigger", int'(conv_trigger), 1);
    chk("t3_overrun_cleared", int'(err_overrun), 0);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;

    // 4a: channel order 0,1,3
    b_done = n_done;
    do_start();
    emit(0, 20); emit(1, 20); emit(3, 20);
    chk("t4_order", int'(err_order), 1);
    chk("t4_busy", int'(busy), 0);
    chk("t4_no_done", n_done - b_done, 0);

    // 4b: chan 1 edge lands on the chan 0 accept edge
    rmode = 2; man_rdy = 1'b0;
    b_beat = n_beat; b_done = n_done; b_q = beat_q.size();
    do_start();
    @(negedge clk); conv_chan = 4'd0; conv_valid = 1'b1;
    repeat (3) @(negedge clk); conv_valid = 1'b0;
    repeat (3) @(negedge clk);
    conv_chan = 4'd1; conv_valid = 1'b1; man_rdy = 1'b1;
    repeat (3) @(negedge clk); conv_valid = 1'b0;
    repeat (12) @(negedge clk);
    for (int c = 2; c < CHAN; c++) emit(c, 20);
    repeat (5) @(negedge clk);
    #3;
    chk("t4b_beats", n_beat - b_beat, 10);
    chk("t4b_second_chan", beat_q[b_q + 1], 1);
    chk("t4b_dones", n_done - b_done, 1);
    chk("t4b_flags", int'({err_order, err_overrun}), 0);

    // 5: watchdog expiry
    rmode = 0;
    b_done = n_done;
    do_start();
    @(negedge clk);
    k = 0;
    while (!err_timeout && k < 200) begin @(negedge clk); k++; end
    chk("t5_timeout_cycles", k, 64);
    chk("t5_busy", int'(busy), 0);
    chk("t5_no_done", n_done - b_done, 0);

    // 6: abort while offering chan 4; start during busy ignored
    rmode = 2; man_rdy = 1'b1;
    b_done = n_done;
    do_start();
    for (int c = 0; c < 4; c++) emit(c, 20);
    man_rdy = 1'b0;
    @(negedge clk); conv_chan = 4'd4; conv_valid = 1'b1;
    k = 0;
    while (!(cons_valid && cons_chan == 4'd4) && k < 50) begin @(negedge clk); k++; end
    chk("t6_offer_chan", int'(cons_chan), 4);
    b_trig = n_trig;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    #3;
    chk("t6_start_ignored", n_trig - b_trig, 0);
    chk("t6_still_offered", int'(cons_valid), 1);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0; conv_valid = 1'b0;
    chk("t6_abort_busy", int'(busy), 0);
    chk("t6_abort_cons_valid", int'(cons_valid), 0);
    repeat (3) @(negedge clk);
    #3;
    chk("t6_no_done", n_done - b_done, 0);

    // 6b: asynchronous reset in the middle of WAIT
    do_start();
    repeat (5) @(negedge clk);
    chk("t6_wait_busy", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_outputs", int'({done, err_timeout, err_order, err_overrun, conv_trigger, cons_valid, cons_last}), 0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/conv1_seq.md
Name: conv1_seq

Overview:
- Channel sequencer for the conv1 datapath: issues the single-cycle `trigger` that starts a full multi-channel conv1 pass.
- Tracks each per-channel `out_valid` rising edge and checks channel order.
- Hands each finished channel buffer to a downstream consumer (pool/fc stage) over a valid/ready handshake.
- Flags a stalled datapath with a watchdog, and flags a consumer too slow to drain a buffer before conv1 overwrites it.

Parameters:
- CHAN, 10, number of output channels conv1 produces per pass.
- CHAN_W, 4, width of channel indices.
- TIMEOUT, 200000, max cycles in WAIT between consecutive channel edges (first edge counted from trigger).
- TMO_W, 18, watchdog counter width; TIMEOUT must fit.

Ports:
- clk, in, 1, system clock, all logic on rising edge.
- rst, in, 1, asynchronous active-high reset.
- start, in, 1, begin a pass; sampled in IDLE or ERR only, ignored otherwise.
- abort, in, 1, cancel from any state.
- busy, out, 1, high in TRIG, WAIT, HAND.
- done, out, 1, one-cycle pulse after last channel accepted.
- err_timeout, out, 1, sticky watchdog expiry.
- err_order, out, 1, sticky out-of-order channel index.
- err_overrun, out, 1, sticky new channel edge while a buffer is still unaccepted.
- conv_trigger, out, 1, to conv1 trigger.
- conv_valid, in, 1, from conv1 out_valid.
- conv_chan, in, CHAN_W, from conv1 out_chan.
- cons_valid, out, 1, channel buffer ready for consumer.
- cons_chan, out, CHAN_W, channel index of the offered buffer.
- cons_last, out, 1, offered channel is CHAN-1.
- cons_ready, in, 1, consumer accepts.

Behaviour:
- All outputs registered.
- Reset value of every output is 0; state = IDLE, exp_chan = 0, watchdog = 0, prev_valid = 0, pend = 0.

Edge detection:
- prev_valid <= conv_valid every cycle in every state.
- rise = conv_valid & ~prev_valid. A level already high at start is not a rise.

States:
- IDLE: start -> TRIG. Error flags cleared on that same edge.
- TRIG: conv_trigger = 1 for exactly this cycle; exp_chan <= 0, watchdog <= 0, pend <= 0 -> WAIT.
- WAIT:
  - watchdog increments each cycle.
  - (rise | pend) with conv_chan == exp_chan: cons_valid <= 1, cons_chan <= conv_chan, cons_last <= (exp_chan == CHAN-1), watchdog <= 0, pend <= 0 -> HAND.
  - (rise | pend) with conv_chan != exp_chan: err_order <= 1 -> ERR.
  - watchdog == TIMEOUT-1 with no rise: err_timeout <= 1 -> ERR.
- HAND:
  - cons_valid, cons_chan, cons_last held stable until cons_ready. Watchdog frozen.
  - cons_ready: cons_valid <= 0. If cons_last -> DONE; else exp_chan++ -> WAIT.
  - rise without cons_ready: err_overrun <= 1, cons_valid <= 0 -> ERR.
  - rise and cons_ready in the same cycle: accept wins and pend <= 1. WAIT consumes pend next cycle against the current conv_chan.
- DONE: done = 1 for one cycle -> IDLE.
- ERR: busy = 0; flags held. start -> TRIG (flags cleared); abort -> IDLE (flags held).

Abort and start:
- abort in any state -> IDLE next cycle; cons_valid and conv_trigger drop to 0; no done; flags unchanged; abort has priority over all transitions.
- start while busy is ignored.

Latency:
- start sampled at edge N -> conv_trigger high in cycle N+1.
- Rise sampled at edge M -> cons_valid high in cycle M+1.
- Accept of last channel at edge K -> done high in cycle K+1.

Decomposition:
- Package npu_pkg:
  - conv1_seq state enum (IDLE, TRIG, WAIT, HAND, DONE, ERR).
  - CONV1_CHAN = 10, CONV1_CHAN_W = 4, CONV1_TIMEOUT = 200000.
- One sub-module, seq_watchdog: clear/enable counter with terminal-count output, parameterised by TIMEOUT/TMO_W.

Test Plan:
1. Nominal pass, TIMEOUT = 64: start; conv_valid pulses 3 cycles high for chan 0..9 spaced 20 cycles; cons_ready tied 1 -> exactly one conv_trigger, 10 cons_valid beats chan 0..9, cons_last only on 9, done 1 cycle after chan 9 accept, no error flags.
2. Backpressure: cons_ready held 0 for 15 cycles per channel with edges spaced 20 -> cons_valid and cons_chan stable while stalled, all 10 delivered, no err_overrun.
3. Overrun: cons_ready 0 for 30 cycles while the chan 1 edge arrives -> err_overrun = 1, state ERR, busy 0, cons_valid 0. A later start clears the flag and re-triggers.
4. Order and simultaneous accept: chan sequence 0,1,3 -> err_order after third edge. Separately, chan 1 rise coinciding with chan 0 accept -> chan 1 offered next, no error.
5. Timeout: TIMEOUT = 64, no conv_valid after trigger -> err_timeout exactly 64 cycles after entering WAIT; no done.
6. Abort and reset: abort in HAND at chan 4 -> IDLE next cycle, cons_valid 0, no done; start during busy ignored. rst asserted mid-WAIT -> all outputs 0 asynchronously.
